pmod_dac_multi: RTL and testbench



---
 rtl/pmod_dac_multi.sv | 244 ++++++++++++++++++++++++
 tb/tb_pmod_dac_multi.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_dac_multi.sv
// Multi-channel PMOD DAC driver: per-channel shadow registers, batched SPI
// mode-0 frames {cmd, addr, data} and per-channel or per-batch LDAC pulses.
`timescale 1ns/1ps

module pmod_dac_multi #(
    parameter int RESOLUTION   = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int CLK_DIV      = 4,
    parameter int LDAC_MODE    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RESOLUTION-1:0]   din,
    input  logic [3:0]              din_ch,
    input  logic                    load_din,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CHANNELS-1:0] pending,
    output logic                    dac_cs_n,
    output logic                    dac_sclk,
    output logic                    dac_din,
    output logic                    dac_ldac_n
);

    localparam int FRAME_BITS = 8 + RESOLUTION;
    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SHIFT,
        S_DESELECT,
        S_LDAC,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [NUM_CHANNELS-1:0] mask_q, mask_d;
    logic [NUM_CHANNELS-1:0] pending_q, pending_d;
    logic [RESOLUTION-1:0]   shadow_q [NUM_CHANNELS];

    logic sclk_q, sclk_d;
    logic sdo_q, sdo_d;
    logic cs_n_q, cs_n_d;
    logic ldac_n_q, ldac_n_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic [NUM_CHANNELS-1:0] wr_hot;
    logic [NUM_CHANNELS-1:0] snap;
    logic [NUM_CHANNELS-1:0] mask_src;
    logic [NUM_CHANNELS-1:0] sel_hot;
    logic [3:0]              sel_ch;
    logic [RESOLUTION-1:0]   sel_data;
    logic                    cnt_last;
    logic                    enter_sel;

    // Out-of-range channel indices match no bit here, so they are dropped.
    always_comb begin
        wr_hot = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            wr_hot[i] = load_din && (din_ch == 4'(i));
        end
    end

    // A same-cycle write keeps its pending bit out of the snapshot.
    assign snap     = pending_q & ~wr_hot;
    assign mask_src = (state_q == S_IDLE) ? snap : mask_q;
    assign sel_hot  = mask_src & (~mask_src + NUM_CHANNELS'(1));
    assign cnt_last = (cnt_q == DIV_LAST);

    always_comb begin
        sel_ch   = '0;
        sel_data = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (mask_src[i]) begin
                sel_ch = 4'(i);
            end
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (sel_ch == 4'(i)) begin
                sel_data = shadow_q[i];
            end
        end
    end

    // NOTE: every variable driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + DIV_W'(1);
        bit_d     = bit_q;
        frame_d   = frame_q;
        mask_d    = mask_q;
        pending_d = pending_q | wr_hot;
        sclk_d    = sclk_q;
        sdo_d     = sdo_q;
        enter_sel = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    pending_d = (pending_q & ~snap) | wr_hot;
                    if (snap != '0) begin
                        enter_sel = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SELECT: begin
                if (cnt_last) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    sdo_d   = frame_q[FRAME_BITS-1];
                end
            end
            S_SHIFT: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = S_DESELECT;
                            sdo_d   = 1'b0;
                        end else begin
                            bit_d   = bit_q + BIT_W'(1);
                            frame_d = frame_q << 1;
                            sdo_d   = frame_q[FRAME_BITS-2];
                        end
                    end
                end
            end
            S_DESELECT: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (LDAC_MODE == 0 || mask_q == '0) begin
                        state_d = S_LDAC;
                    end else begin
                        enter_sel = 1'b1;
                    end
                end
            end
            S_LDAC: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (mask_q != '0) begin
                        enter_sel = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The frame is captured here, so later shadow writes cannot alter it.
        if (enter_sel) begin
            state_d = S_SELECT;
            cnt_d   = '0;
            bit_d   = '0;
            mask_d  = mask_src & ~sel_hot;
            frame_d = {4'b0000, sel_ch, sel_data};
        end
    end

    // All pins are registered from the next state.
    always_comb begin
        cs_n_d   = !(state_d == S_SELECT || state_d == S_SHIFT);
        ldac_n_d = (state_d != S_LDAC);
        busy_d   = (state_d == S_SELECT) || (state_d == S_SHIFT) ||
                   (state_d == S_DESELECT) || (state_d == S_LDAC);
        done_d   = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            frame_q   <= '0;
            mask_q    <= '0;
            pending_q <= '0;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            ldac_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            // NOTE: the shadow array is cleared on reset because stale data
            // must never reach a DAC; this keeps it in flops, not RAM.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            sclk_q    <= sclk_d;
            sdo_q     <= sdo_d;
            cs_n_q    <= cs_n_d;
            ldac_n_q  <= ldac_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (wr_hot[i]) begin
                    shadow_q[i] <= din;
                end
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pending    = pending_q;
    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_din    = sdo_q;
    assign dac_ldac_n = ldac_n_q;

endmodule

// File: tb/tb_pmod_dac_multi.sv
// Bench for pmod_dac_multi: two instances (per-channel and per-batch LDAC)
// share one stimulus; a pin monitor decodes frames, LDAC pulses and timing.
`timescale 1ns/1ps

module tb_pmod_dac_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic [3:0]  din_ch;
    logic        load_din;
    logic        start;
    logic [1:0]  busy, done, cs_n, sclk, sdo, ldac_n;
    logic [1:0][3:0] pend;

    always #5 clk = ~clk;

    pmod_dac_multi #(.RESOLUTION(16), .NUM_CHANNELS(4), .CLK_DIV(2), .LDAC_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .din(din), .din_ch(din_ch), .load_din(load_din),
        .start(start), .busy(busy[0]), .done(done[0]), .pending(pend[0]),
        .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]), .dac_din(sdo[0]), .dac_ldac_n(ldac_n[0])
    );

    pmod_dac_multi #(.RESOLUTION(16), .NUM_CHANNELS(4), .CLK_DIV(2), .LDAC_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .din(din), .din_ch(din_ch), .load_din(load_din),
        .start(start), .busy(busy[1]), .done(done[1]), .pending(pend[1]),
        .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]), .dac_din(sdo[1]), .dac_ldac_n(ldac_n[1])
    );

    // ---------------- pin monitor (samples on the falling clk edge) ----------
    logic        mon_clr = 1'b1;
    int          cyc = 0;
    int          nfrm[2], nldac[2], ndone[2], cs_falls[2], rises[2], bits[2];
    int          per_bad[2], sclk_bad[2], ldac_wbad[2];
    int          cs_fall_cyc[2], ldac_fall_cyc[2], last_rise[2];
    logic [23:0] sh[2];
    logic [23:0] frm[2][8];
    int          fbits[2][8], cslow[2][8], ldac_after[2][8];
    logic [1:0]  p_cs = 2'b11, p_sclk = 2'b00, p_ldac = 2'b11;

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (mon_clr) begin
                nfrm[k] = 0; nldac[k] = 0; ndone[k] = 0; cs_falls[k] = 0;
                rises[k] = 0; bits[k] = 0; per_bad[k] = 0; sclk_bad[k] = 0;
                ldac_wbad[k] = 0; sh[k] = '0; cs_fall_cyc[k] = 0;
                ldac_fall_cyc[k] = 0; last_rise[k] = 0;
            end else begin
                if (p_cs[k] && !cs_n[k]) begin
                    cs_fall_cyc[k] = cyc; sh[k] = '0; bits[k] = 0;
                    cs_falls[k] = cs_falls[k] + 1;
                end
                if (!p_sclk[k] && sclk[k]) begin
                    sh[k] = {sh[k][22:0], sdo[k]};
                    if (bits[k] > 0 && (cyc - last_rise[k]) != 4) per_bad[k] = per_bad[k] + 1;
                    last_rise[k] = cyc;
                    bits[k] = bits[k] + 1;
                    rises[k] = rises[k] + 1;
                end
                if (sclk[k] && cs_n[k]) sclk_bad[k] = sclk_bad[k] + 1;
                if (!p_cs[k] && cs_n[k] && nfrm[k] < 8) begin
                    frm[k][nfrm[k]]   = sh[k];
                    fbits[k][nfrm[k]] = bits[k];
                    cslow[k][nfrm[k]] = cyc - cs_fall_cyc[k];
                    nfrm[k] = nfrm[k] + 1;
                end
                if (p_ldac[k] && !ldac_n[k] && nldac[k] < 8) begin
                    ldac_fall_cyc[k] = cyc;
                    ldac_after[k][nldac[k]] = nfrm[k];
                    nldac[k] = nldac[k] + 1;
                end
                if (!p_ldac[k] && ldac_n[k] && (cyc - ldac_fall_cyc[k]) != 2)
                    ldac_wbad[k] = ldac_wbad[k] + 1;
                if (done[k]) ndone[k] = ndone[k] + 1;
            end
        end
        p_cs = cs_n; p_sclk = sclk; p_ldac = ldac_n;
    end

    // ---------------- checking helpers --------------------------------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] ch, input logic [15:0] d);
        din = d; din_ch = ch; load_din = 1'b1;
        tick();
        load_din = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clr();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy != 2'b00 && n < 5000) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, 32'(n < 5000), 32'd1);
        tick();
        tick();
    endtask

    // Common per-frame timing checks for both instances.
    task automatic check_timing(input string name, input int k, input int nf);
        check($sformatf("%s_nfrm_d%0d", name, k), 32'(nfrm[k]), 32'(nf));
        for (int f = 0; f < nf && f < 8; f++) begin
            check($sformatf("%s_bits%0d_d%0d", name, f, k), 32'(fbits[k][f]), 32'd24);
            check($sformatf("%s_cslow%0d_d%0d", name, f, k), 32'(cslow[k][f]), 32'd98);
        end
        check($sformatf("%s_period_d%0d", name, k), 32'(per_bad[k]), 32'd0);
        check($sformatf("%s_sclk_cs_d%0d", name, k), 32'(sclk_bad[k]), 32'd0);
        check($sformatf("%s_ldacw_d%0d", name, k), 32'(ldac_wbad[k]), 32'd0);
        check($sformatf("%s_done_d%0d", name, k), 32'(ndone[k]), 32'd1);
    endtask

    typedef struct {
        logic [3:0]  ch;
        logic [15:0] data;
        logic [3:0]  exp_pend;
        logic [23:0] exp_frame;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{ch: 4'd2, data: 16'hABCD, exp_pend: 4'b0100, exp_frame: 24'h02ABCD};
        vecs[1] = '{ch: 4'd0, data: 16'h0000, exp_pend: 4'b0001, exp_frame: 24'h000000};
        vecs[2] = '{ch: 4'd3, data: 16'hFFFF, exp_pend: 4'b1000, exp_frame: 24'h03FFFF};
        vecs[3] = '{ch: 4'd1, data: 16'h8001, exp_pend: 4'b0010, exp_frame: 24'h018001};

        rst = 1'b1; din = '0; din_ch = '0; load_din = 1'b0; start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        mon_clr = 1'b0;
        tick();

        // Reset state
        check("rst_cs_n", 32'(cs_n), 32'h3);
        check("rst_sclk", 32'(sclk), 32'h0);
        check("rst_din", 32'(sdo), 32'h0);
        check("rst_ldac_n", 32'(ldac_n), 32'h3);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_pending", 32'(pend), 32'h0);

        // Single-channel frames
        for (int i = 0; i < 4; i++) begin
            clr();
            load(vecs[i].ch, vecs[i].data);
            check($sformatf("t%0d_pend_before", i), 32'(pend), 32'({vecs[i].exp_pend, vecs[i].exp_pend}));
            go();
            check($sformatf("t%0d_busy_rise", i), 32'(busy), 32'h3);
            wait_idle($sformatf("t%0d", i));
            for (int k = 0; k < 2; k++) begin
                check_timing($sformatf("t%0d", i), k, 1);
                check($sformatf("t%0d_frame_d%0d", i, k), 32'(frm[k][0]), 32'(vecs[i].exp_frame));
                check($sformatf("t%0d_nldac_d%0d", i, k), 32'(nldac[k]), 32'd1);
            end
            check($sformatf("t%0d_pend_after", i), 32'(pend), 32'h0);
        end

        // Batch, write during busy, start during busy
        clr();
        load(4'd3, 16'h1111);
        load(4'd0, 16'h2222);
        load(4'd1, 16'h3333);
        check("batch_pend_before", 32'(pend), 32'hBB);
        go();
        repeat (20) tick();
        load(4'd0, 16'h5555);
        repeat (20) tick();
        go();
        wait_idle("batch");
        for (int k = 0; k < 2; k++) begin
            check_timing("batch", k, 3);
            check($sformatf("batch_f0_d%0d", k), 32'(frm[k][0]), 32'h002222);
            check($sformatf("batch_f1_d%0d", k), 32'(frm[k][1]), 32'h013333);
            check($sformatf("batch_f2_d%0d", k), 32'(frm[k][2]), 32'h031111);
        end
        check("batch_nldac_mode0", 32'(nldac[0]), 32'd3);
        for (int j = 0; j < 3; j++)
            check($sformatf("batch_ldac%0d_mode0_after", j), 32'(ldac_after[0][j]), 32'(j + 1));
        check("batch_nldac_mode1", 32'(nldac[1]), 32'd1);
        check("batch_ldac_mode1_after", 32'(ldac_after[1][0]), 32'd3);
        check("batch_pend_after", 32'(pend), 32'h11);

        clr();
        go();
        wait_idle("resend");
        for (int k = 0; k < 2; k++) begin
            check_timing("resend", k, 1);
            check($sformatf("resend_frame_d%0d", k), 32'(frm[k][0]), 32'h005555);
        end
        check("resend_pend", 32'(pend), 32'h0);

        // Empty batch: done one cycle after start, no SPI activity
        clr();
        go();
        check("empty_done", 32'(done), 32'h3);
        check("empty_busy", 32'(busy), 32'h0);
        tick();
        check("empty_done_fall", 32'(done), 32'h0);
        tick();
        check("empty_cs_falls", 32'(cs_falls[0] + cs_falls[1]), 32'd0);
        check("empty_ndone", 32'(ndone[0] + ndone[1]), 32'd2);

        // Out-of-range channel index is ignored
        clr();
        load(4'd3, 16'h1234);
        load(4'd7, 16'hDEAD);
        check("oor_pend", 32'(pend), 32'h88);
        go();
        wait_idle("oor");
        for (int k = 0; k < 2; k++)
            check($sformatf("oor_frame_d%0d", k), 32'(frm[k][0]), 32'h031234);

        // Mid-frame reset at bit 10
        clr();
        load(4'd1, 16'h00FF);
        go();
        load(4'd2, 16'h4444);
        begin
            int n;
            n = 0;
            while (rises[0] < 10 && n < 2000) begin
                tick();
                n++;
            end
            check("mid_wait_timeout", 32'(n < 2000), 32'd1);
        end
        check("mid_pend_before", 32'(pend), 32'h44);
        rst = 1'b1;
        tick();
        check("mid_cs_n", 32'(cs_n), 32'h3);
        check("mid_sclk", 32'(sclk), 32'h0);
        check("mid_din", 32'(sdo), 32'h0);
        check("mid_ldac_n", 32'(ldac_n), 32'h3);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_done", 32'(done), 32'h0);
        check("mid_pend", 32'(pend), 32'h0);
        rst = 1'b0;
        repeat (20) tick();
        check("mid_no_ldac", 32'(nldac[0] + nldac[1]), 32'd0);
        check("mid_no_refall", 32'(cs_falls[0] + cs_falls[1]), 32'd2);

        clr();
        load(4'd2, 16'hBEEF);
        go();
        wait_idle("fresh");
        for (int k = 0; k < 2; k++) begin
            check_timing("fresh", k, 1);
            check($sformatf("fresh_frame_d%0d", k), 32'(frm[k][0]), 32'h02BEEF);
            check($sformatf("fresh_nldac_d%0d", k), 32'(nldac[k]), 32'd1);
        end
        check("fresh_pend", 32'(pend), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
